// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// blank code and default slot timing.
package seg_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } seg_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int DEF_NDIG        = 4;
  localparam int DEF_ON_TICKS    = 4;
  localparam int DEF_GUARD_TICKS = 1;

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression: marks which digits of the active frame may be
// lit. Digit 0 is always visible so an all-zero frame still reads "0".
module seg_lz_mask #(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] frame,
  input  logic              lz_en,
  output logic [NDIG-1:0]   show
);

  logic zero_above;

  always_comb begin
    show       = '1;
    zero_above = 1'b1;
    if (lz_en) begin
      // Walk from the most significant digit down; suppression stops at the
      // first non-zero digit.
      for (int i = NDIG - 1; i >= 1; i--) begin
        zero_above = zero_above & (frame[4*i +: 4] == 4'd0);
        show[i]    = ~zero_above;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode digit bank with guard slots and a
// frame-synchronous load handshake for the displayed digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG        = DEF_NDIG,
  parameter int ON_TICKS    = DEF_ON_TICKS,
  parameter int GUARD_TICKS = DEF_GUARD_TICKS
) (
  input  logic              clk_fast_out,
  input  logic              rst,
  input  logic [4*NDIG-1:0] din,
  input  logic [NDIG-1:0]   en_mask,
  input  logic              lz_en,
  input  logic              load_req,
  output logic              load_ack,
  output logic [NDIG-1:0]   scan,
  output logic [3:0]        bcd_out,
  output logic              blank,
  output logic              frame_done
);

  localparam int MAX_TICKS = (ON_TICKS > GUARD_TICKS) ? ON_TICKS : GUARD_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int IW        = $clog2(NDIG);

  seg_state_t        state;
  logic [TW-1:0]     tick;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] active;
  logic [NDIG-1:0]   show;

  logic [3:0]        cur_digit;
  logic              cur_en;
  logic              cur_show;
  logic              visible;
  logic [NDIG-1:0]   onehot;

  seg_lz_mask #(.NDIG(NDIG)) u_lz_mask (
    .frame (active),
    .lz_en (lz_en),
    .show  (show)
  );

  always_comb begin
    cur_digit = 4'd0;
    cur_en    = 1'b0;
    cur_show  = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = active[4*i +: 4];
        cur_en    = en_mask[i];
        cur_show  = show[i];
        onehot[i] = 1'b1;
      end
    end
    visible = cur_en & cur_show & (cur_digit <= 4'd9);
  end

  always_ff @(posedge clk_fast_out or posedge rst) begin
    if (rst) begin
      state      <= ST_GUARD;
      tick       <= '0;
      idx        <= '0;
      active     <= '0;
      scan       <= '0;
      bcd_out    <= 4'd0;
      blank      <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
      case (state)
        ST_GUARD: begin
          if (tick == TW'(GUARD_TICKS - 1)) begin
            tick    <= '0;
            state   <= ST_ON;
            // Out-of-range codes never reach the decoder.
            bcd_out <= (cur_digit <= 4'd9) ? cur_digit : BLANK_CODE;
            scan    <= visible ? onehot : '0;
            blank   <= ~visible;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        ST_ON: begin
          if (tick == TW'(ON_TICKS - 1)) begin
            tick  <= '0;
            state <= ST_GUARD;
            scan  <= '0;
            blank <= 1'b1;
            if (idx == IW'(NDIG - 1)) begin
              // Frame boundary: the only point where the active frame changes.
              idx        <= '0;
              frame_done <= 1'b1;
              if (load_req) begin
                active   <= din;
                load_ack <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= ST_GUARD;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with default parameters (4 digits,
// 1 guard + 4 on cycles per digit, 20-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk_fast_out = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0;
  logic [3:0]  en_mask = 4'hF;
  logic        lz_en = 1'b0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [3:0]  scan;
  logic [3:0]  bcd_out;
  logic        blank;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  seg_scan_ctrl dut (
    .clk_fast_out (clk_fast_out),
    .rst          (rst),
    .din          (din),
    .en_mask      (en_mask),
    .lz_en        (lz_en),
    .load_req     (load_req),
    .load_ack     (load_ack),
    .scan         (scan),
    .bcd_out      (bcd_out),
    .blank        (blank),
    .frame_done   (frame_done)
  );

  always #5 clk_fast_out = ~clk_fast_out;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Counts negedges until frame_done is seen, bounded at 60 cycles.
  task automatic wait_frame(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_fast_out);
      cnt++;
    end while (!frame_done && cnt < 60);
  endtask

  // Called at cycle 0 of a frame (frame_done just seen); checks all 20
  // cycles and lands on cycle 0 of the next frame.
  task automatic check_frame(input logic [3:0] lit, input logic [15:0] vals,
                             input int req_on, input int req_off,
                             input logic [15:0] new_din, input logic exp_ack);
    int d;
    int pos;
    for (int c = 0; c < 20; c++) begin
      d   = c / 5;
      pos = c % 5;
      if (c > 0) begin
        chk($sformatf("frame_done c%0d", c), frame_done, 0);
        chk($sformatf("load_ack c%0d", c), load_ack, 0);
      end
      if (pos == 0) begin
        chk($sformatf("guard scan c%0d", c), scan, 0);
        chk($sformatf("guard blank c%0d", c), blank, 1);
      end else begin
        chk($sformatf("scan c%0d", c), scan, lit[d] ? (4'b0001 << d) : 4'b0000);
        chk($sformatf("blank c%0d", c), blank, !lit[d]);
        if (lit[d]) chk($sformatf("bcd c%0d", c), bcd_out, vals[4*d +: 4]);
      end
      if (c == req_on) begin
        din      = new_din;
        load_req = 1'b1;
      end
      if (c == req_off) load_req = 1'b0;
      @(negedge clk_fast_out);
    end
    chk("frame_done boundary", frame_done, 1);
    chk("load_ack boundary", load_ack, exp_ack);
  endtask

  initial begin
    repeat (3) @(negedge clk_fast_out);
    chk("rst scan", scan, 0);
    chk("rst bcd", bcd_out, 0);
    chk("rst blank", blank, 1);
    chk("rst ack", load_ack, 0);
    chk("rst frame_done", frame_done, 0);

    rst      = 1'b0;
    din      = 16'h1234;
    load_req = 1'b1;
    wait_frame(n);
    chk("first frame length", n, 20);
    chk("first commit ack", load_ack, 1);
    load_req = 1'b0;

    // 0x1234 shown; request 0x0507 at cycle 7, committed at this boundary.
    check_frame(4'hF, 16'h1234, 7, -1, 16'h0507, 1'b1);
    load_req = 1'b0;
    check_frame(4'hF, 16'h0507, 2, -1, 16'h0040, 1'b1);
    load_req = 1'b0;
    lz_en    = 1'b1;
    check_frame(4'b0011, 16'h0040, 5, -1, 16'h0000, 1'b1);
    load_req = 1'b0;
    check_frame(4'b0001, 16'h0000, 3, -1, 16'h9A12, 1'b1);
    load_req = 1'b0;
    lz_en    = 1'b0;
    en_mask  = 4'b0101;
    // Three-cycle request that is withdrawn: no ack, frame unchanged.
    check_frame(4'b0001, 16'h9A12, 6, 9, 16'h5555, 1'b0);
    check_frame(4'b0001, 16'h9A12, 4, -1, 16'h3210, 1'b1);
    load_req = 1'b0;
    en_mask  = 4'hF;

    // Reset during digit 2 ON slot with a request pending.
    for (int c = 0; c < 12; c++) begin
      if (c == 8) begin
        din      = 16'h3333;
        load_req = 1'b1;
      end
      @(negedge clk_fast_out);
    end
    chk("pre-reset scan", scan, 4'b0100);
    chk("pre-reset bcd", bcd_out, 2);
    #1 rst = 1'b1;
    #1;
    chk("async rst scan", scan, 0);
    chk("async rst blank", blank, 1);
    chk("async rst bcd", bcd_out, 0);
    repeat (2) @(negedge clk_fast_out);
    rst = 1'b0;
    @(negedge clk_fast_out);
    chk("post-reset digit0 scan", scan, 4'b0001);
    chk("post-reset digit0 bcd", bcd_out, 0);
    chk("post-reset frame_done", frame_done, 0);
    wait_frame(n);
    chk("post-reset frame length", n, 19);
    chk("post-reset commit ack", load_ack, 1);
    load_req = 1'b0;
    check_frame(4'hF, 16'h3333, -1, -1, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
